imem_prefetch_buf: RTL and testbench

Sequential instruction prefetch buffer between the instruction cache's memory-request port and the instruction memory. It serves single-word line-fill reads from a small FIFO of contiguous words that were fetched speculatively. On a miss it performs a demand fetch, then refills the window ahead of the last served address. The goal is fewer exposed imem latencies on sequential line fills, with data returned unchanged.

---
 rtl/imem_prefetch_buf.sv | 177 +++++++++++++++++
 tb/tb_imem_prefetch_buf.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prefetch_buf.sv
// imem_prefetch_buf: sequential instruction prefetch buffer.
//
// Sits between the I-cache line-fill port (up_*) and instruction memory
// (mem_*). Serves single-word reads from a small window of contiguous words
// fetched ahead of the last served address; on a miss it flushes the window,
// performs a demand fetch and then refills the window behind it.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   up_valid/up_addr    cache read request (held until up_ready)
//   up_ready/up_rdata   one-cycle response pulse with the word
//   mem_valid/mem_addr  imem fetch request (held until mem_ready)
//   mem_ready/mem_rdata one-cycle imem completion with the word
//
// Optional: define IMEM_PREFETCH_STATS_EN to add stat_hits, stat_misses and
// stat_prefetches counter outputs.
module imem_prefetch_buf #(
  parameter int          DEPTH     = 4,
  parameter int unsigned MEM_BYTES = 32'd1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_valid,
  output logic        up_ready,
  input  logic [31:0] up_addr,
  output logic [31:0] up_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
`ifdef IMEM_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_prefetches
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {U_IDLE, U_WAIT, U_RESP} u_state_t;
  typedef enum logic {M_IDLE, M_BUSY} m_state_t;
  typedef enum logic [1:0] {T_DEMAND, T_PREFETCH, T_DISCARD} tag_t;

  u_state_t u_state, u_next;
  m_state_t m_state, m_next;
  tag_t     tag;

  logic [31:0]   base;
  logic [CW-1:0] count;
  logic [31:0]   req_addr;
  // Words live in the slot selected by their own address bits, so the
  // window never has to be shifted when words are consumed or appended.
  logic [31:0]   data_q [DEPTH];

  logic [31:0] req_a, off, off_w, count32, nf;
  logic sample, buf_hit, inflight, hit_now, ifh_now, miss_now;
  logic mem_done, wait_resp, fast_resp, append, issue_dm, issue_pf;

  always_comb begin
    req_a    = up_addr & ~32'h3;
    off      = req_a - base;
    off_w    = off >> 2;
    count32  = 32'(count);
    buf_hit  = off_w < count32;  // modulo compare covers A < base too
    nf       = base + (count32 << 2);
    sample   = (u_state == U_IDLE) && up_valid;
    inflight = (m_state == M_BUSY) && (tag == T_PREFETCH) && (mem_addr == req_a);
    hit_now  = sample && buf_hit;
    ifh_now  = sample && !buf_hit && inflight;
    miss_now = sample && !buf_hit && !inflight;
    mem_done = (m_state == M_BUSY) && mem_ready;
    // U_WAIT only ever waits on a DEMAND or on the in-flight PREFETCH it hit.
    wait_resp = (u_state == U_WAIT) && mem_done && (tag != T_DISCARD);
    // In-flight hit sampled in the very cycle the prefetch completes.
    fast_resp = ifh_now && mem_ready;
    append    = mem_done && (tag == T_PREFETCH) && (u_state != U_WAIT) &&
                !miss_now && !ifh_now;
    issue_dm  = (m_state == M_IDLE) && (u_state == U_WAIT);
    // A miss being sampled this cycle must not let a prefetch steal imem.
    issue_pf  = (m_state == M_IDLE) && (u_state != U_WAIT) && !miss_now &&
                (count32 < 32'(DEPTH)) && (nf < MEM_BYTES);
  end

  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE: begin
        if (hit_now || fast_resp)     u_next = U_RESP;
        else if (ifh_now || miss_now) u_next = U_WAIT;
      end
      U_WAIT:  if (wait_resp) u_next = U_RESP;
      U_RESP:  u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:  if (issue_dm || issue_pf) m_next = M_BUSY;
      M_BUSY:  if (mem_ready) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  assign up_ready  = (u_state == U_RESP);
  assign mem_valid = (m_state == M_BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state  <= U_IDLE;
      m_state  <= M_IDLE;
      tag      <= T_DEMAND;
      base     <= '0;
      count    <= '0;
      req_addr <= '0;
      up_rdata <= '0;
      mem_addr <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      u_state <= u_next;
      m_state <= m_next;

      if (issue_dm) begin
        mem_addr <= req_addr;
        tag      <= T_DEMAND;
      end else if (issue_pf) begin
        mem_addr <= nf;
        tag      <= T_PREFETCH;
      end else if (miss_now && (m_state == M_BUSY)) begin
        tag <= T_DISCARD;
      end

      if (sample) req_addr <= req_a;
      if (append) data_q[mem_addr[IW+1:2]] <= mem_rdata;

      if (hit_now)                     up_rdata <= data_q[req_a[IW+1:2]];
      else if (wait_resp || fast_resp) up_rdata <= mem_rdata;

      // Window bookkeeping; a miss flushes even if a prefetch lands now.
      if (miss_now) begin
        count <= '0;
      end else if (wait_resp) begin
        base  <= req_addr + 32'd4;
        count <= '0;
      end else if (fast_resp) begin
        base  <= req_a + 32'd4;
        count <= '0;
      end else if (hit_now) begin
        // Skipped words are dropped; a same-cycle append still lands at the
        // (unchanged) next-fetch address, which stays contiguous.
        base  <= req_a + 32'd4;
        count <= count - CW'(off_w) - CW'(1) + CW'(append);
      end else if (append) begin
        count <= count + CW'(1);
      end
    end
  end

`ifdef IMEM_PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_prefetches <= '0;
    end else begin
      if (hit_now || fast_resp || (wait_resp && (tag == T_PREFETCH)))
        stat_hits <= stat_hits + 32'd1;
      if (miss_now) stat_misses <= stat_misses + 32'd1;
      if (issue_pf) stat_prefetches <= stat_prefetches + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_prefetch_buf.sv
// Directed self-checking bench for imem_prefetch_buf (DEPTH 4, 1 MiB imem).
// A behavioural imem with programmable latency answers fetches and logs
// every completed fetch address.
module tb_imem_prefetch_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_addr;
  logic [31:0] up_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
`ifdef IMEM_PREFETCH_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_prefetches;
`endif

  imem_prefetch_buf #(.DEPTH(4), .MEM_BYTES(32'd1048576)) dut (
    .clk(clk), .reset(reset),
    .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr), .up_rdata(up_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef IMEM_PREFETCH_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_prefetches(stat_prefetches)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic [31:0] flog[$];
  bit saw_top = 1'b0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'h5AC3, a[31:16] ^ 16'h1F0E} + 32'h0000_0101;
  endfunction

  // imem model: answers after `lat` cycles of mem_valid, logs completions.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid && (mem_addr == 32'h0010_0000)) saw_top = 1'b1;
      if (mem_valid && !mem_ready) begin
        if (wcnt + 1 >= lat) begin
          mem_ready = 1'b1;
          mem_rdata = memval(mem_addr);
          flog.push_back(mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Issue one request; cyc = edges until up_ready seen, -1 on timeout.
  task automatic do_req(input logic [31:0] a, output logic [31:0] d, output int cyc);
    bit got;
    got = 1'b0;
    d = '0;
    @(negedge clk);
    up_addr = a;
    up_valid = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (up_ready) begin
        d = up_rdata;
        got = 1'b1;
      end
    end
    up_valid = 1'b0;
    if (!got) cyc = -1;
  endtask

  task automatic wait_mem_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if (mem_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit ok;
    reset = 1'b1; up_valid = 1'b0; up_addr = '0;
    #1;
    checks++;
    if ({up_ready, mem_valid, up_rdata, mem_addr} !== 66'd0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%0b mv=%0b rd=%h ma=%h, want all 0",
                         up_ready, mem_valid, up_rdata, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // count 0 / base 0 after reset: the window starts filling from address 0.
    wait_mem_valid(ok);
    checks++;
    if (!ok || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_prefetch: ok=%0b addr=%h, want addr 0", ok, mem_addr);
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (flog.size() != 4 || flog[0] !== 32'h0 || flog[3] !== 32'hC || mem_valid !== 1'b0) begin
      errors++; $display("FAIL reset_fill_depth: n=%0d mv=%0b, want 4 fetches 0..C then idle",
                         flog.size(), mem_valid);
    end
  endtask

  task automatic test_cold_miss;
    logic [31:0] d; int cyc;
    flog.delete();
    lat = 1;
    do_req(32'h100, d, cyc);
    checks++;
    if (cyc != 3 || d !== memval(32'h100)) begin
      errors++; $display("FAIL cold_miss_resp: cyc=%0d data=%h, want cyc 3 data %h", cyc, d, memval(32'h100));
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (flog.size() != 5 || flog[0] !== 32'h100 || flog[1] !== 32'h104 || flog[2] !== 32'h108 ||
        flog[3] !== 32'h10C || flog[4] !== 32'h110 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL cold_miss_prefetch: n=%0d last=%h mv=%0b, want 100,104,108,10C,110 then idle",
                         flog.size(), flog.size() ? flog[flog.size()-1] : 32'h0, mem_valid);
    end
  endtask

  task automatic test_skip_hit;
    logic [31:0] d; int cyc;
    flog.delete();
    do_req(32'h10C, d, cyc);
    checks++;
    if (cyc != 1 || d !== memval(32'h10C) || flog.size() != 0) begin
      errors++; $display("FAIL skip_hit_resp: cyc=%0d data=%h fetches=%0d, want 1 %h 0",
                         cyc, d, memval(32'h10C), flog.size());
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (flog.size() != 3 || flog[0] !== 32'h114 || flog[2] !== 32'h11C) begin
      errors++; $display("FAIL skip_hit_refill: n=%0d first=%h, want 114,118,11C",
                         flog.size(), flog.size() ? flog[0] : 32'h0);
    end
  endtask

  task automatic test_seq_hit;
    logic [31:0] d; int cyc; bit ok;
    flog.delete();
    lat = 6;  // keep the following prefetch in flight for the branch test
    do_req(32'h110, d, cyc);
    checks++;
    if (cyc != 1 || d !== memval(32'h110) || flog.size() != 0) begin
      errors++; $display("FAIL seq_hit_resp: cyc=%0d data=%h fetches=%0d, want 1 %h 0",
                         cyc, d, memval(32'h110), flog.size());
    end
    wait_mem_valid(ok);
    checks++;
    if (!ok || mem_addr !== 32'h120) begin
      errors++; $display("FAIL seq_hit_prefetch: ok=%0b addr=%h, want 120", ok, mem_addr);
    end
  endtask

  task automatic test_branch_miss;
    logic [31:0] d; int cyc; bit ok;
    do_req(32'h200, d, cyc);
    checks++;
    if (cyc < 2 || d !== memval(32'h200)) begin
      errors++; $display("FAIL branch_resp: cyc=%0d data=%h, want miss with data %h", cyc, d, memval(32'h200));
    end
    checks++;
    if (flog.size() != 2 || flog[0] !== 32'h120 || flog[1] !== 32'h200) begin
      errors++; $display("FAIL branch_order: n=%0d, want fetches 120 (dropped) then 200", flog.size());
    end
    wait_mem_valid(ok);
    checks++;
    if (!ok || mem_addr !== 32'h204) begin
      errors++; $display("FAIL branch_restart: ok=%0b addr=%h, want 204", ok, mem_addr);
    end
  endtask

  task automatic test_inflight_hit;
    logic [31:0] d; int cyc; bit ok;
    do_req(32'h204, d, cyc);
    checks++;
    if (cyc < 2 || d !== memval(32'h204)) begin
      errors++; $display("FAIL inflight_resp: cyc=%0d data=%h, want waited data %h", cyc, d, memval(32'h204));
    end
    wait_mem_valid(ok);
    checks++;
    if (!ok || mem_addr !== 32'h208 || flog[flog.size()-1] !== 32'h204) begin
      errors++; $display("FAIL inflight_next: ok=%0b addr=%h, want 208 with no refetch of 204", ok, mem_addr);
    end
  endtask

  task automatic test_top_boundary;
    logic [31:0] d; int cyc;
    lat = 1;
    do_req(32'hFFFF8, d, cyc);
    flog.delete();
    checks++;
    if (cyc < 2 || d !== memval(32'hFFFF8)) begin
      errors++; $display("FAIL top_resp: cyc=%0d data=%h, want %h", cyc, d, memval(32'hFFFF8));
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (flog.size() != 1 || flog[0] !== 32'hFFFFC || mem_valid !== 1'b0 || saw_top) begin
      errors++; $display("FAIL top_prefetch: n=%0d mv=%0b saw_top=%0b, want only FFFFC",
                         flog.size(), mem_valid, saw_top);
    end
    do_req(32'hFFFFC, d, cyc);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (cyc != 1 || d !== memval(32'hFFFFC) || mem_valid !== 1'b0 || saw_top) begin
      errors++; $display("FAIL top_last_hit: cyc=%0d data=%h mv=%0b saw_top=%0b, want 1 %h 0 0",
                         cyc, d, mem_valid, saw_top, memval(32'hFFFFC));
    end
  endtask

  task automatic test_reset_midrun;
    bit ok, seen;
    lat = 8;
    @(negedge clk);
    up_addr = 32'h300;
    up_valid = 1'b1;
    wait_mem_valid(ok);
    #2 reset = 1'b1;
    up_valid = 1'b0;
    #1;
    checks++;
    if (!ok || up_ready !== 1'b0 || mem_valid !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL midrun_reset: ok=%0b rdy=%0b mv=%0b ma=%h, want 1 0 0 0",
                         ok, up_ready, mem_valid, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    flog.delete();
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (up_ready) seen = 1'b1;
    end
    checks++;
    if (seen || flog.size() == 0 || flog[0] !== 32'h0) begin
      errors++; $display("FAIL midrun_after: resp=%0b n=%0d, want no response and refill from 0",
                         seen, flog.size());
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_skip_hit();
    test_seq_hit();
    test_branch_miss();
    test_inflight_hit();
    test_top_boundary();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
